// File: rtl/gate3_resp_checker.sv
// Response checker for 3-input OR/NOR gate cells: counts beats and mismatches, tracks
// input coverage and the first failure. Optional macro GATE3_CHK_STOP_ON_ERR_EN ends a run on the first mismatch.
module gate3_resp_checker #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             in_valid,
  input  logic [2:0]       in_abc,
  input  logic             in_or,
  input  logic             in_nor,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [7:0]       cov,
  output logic             fail_seen,
  output logic [2:0]       first_fail_abc,
  output logic [1:0]       first_fail_res
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef GATE3_CHK_STOP_ON_ERR_EN
  localparam logic STOP_ON_ERR = 1'b1;
`else
  localparam logic STOP_ON_ERR = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0] state;
  logic       accept;
  logic       exp_or;
  logic       exp_nor;
  logic       mismatch;
  logic [7:0] cov_nxt;

  assign in_ready = (state == S_RUN);
  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);
  // err_cnt saturates at all-ones, so it can never wrap back to zero after a mismatch
  assign pass     = done & (err_cnt == '0);

  assign accept   = in_valid & in_ready;
  assign exp_or   = |in_abc;
  assign exp_nor  = ~|in_abc;
  assign mismatch = (in_or != exp_or) | (in_nor != exp_nor);
  assign cov_nxt  = cov | (8'b1 << in_abc);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= S_IDLE;
      vec_cnt        <= '0;
      err_cnt        <= '0;
      cov            <= '0;
      fail_seen      <= 1'b0;
      first_fail_abc <= '0;
      first_fail_res <= '0;
    end else if (start) begin
      // start wins over a coincident beat; that beat is dropped
      state          <= S_RUN;
      vec_cnt        <= '0;
      err_cnt        <= '0;
      cov            <= '0;
      fail_seen      <= 1'b0;
      first_fail_abc <= '0;
      first_fail_res <= '0;
    end else if (accept) begin
      cov <= cov_nxt;
      if (vec_cnt != CNT_MAX) vec_cnt <= vec_cnt + CNT_ONE;
      if (mismatch) begin
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
        if (!fail_seen) begin
          fail_seen      <= 1'b1;
          first_fail_abc <= in_abc;
          first_fail_res <= {in_or, in_nor};
        end
      end
      if ((cov_nxt == 8'hFF) || (STOP_ON_ERR && mismatch)) state <= S_DONE;
    end
  end

endmodule

// File: tb/tb_gate3_resp_checker.sv
// Bench for gate3_resp_checker: directed test-plan runs plus random traffic, checked
// every cycle against a behavioural model; a CNT_W=2 instance shares the stimulus for saturation.
module tb_gate3_resp_checker;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST = 1'b1, start = 1'b0, in_valid = 1'b0, in_or = 1'b0, in_nor = 1'b0;
  logic [2:0] in_abc = 3'd0;

  logic       a_rdy, a_busy, a_done, a_pass, a_fs;
  logic [7:0] a_vec, a_err, a_cov;
  logic [2:0] a_ffa;
  logic [1:0] a_ffr;
  logic       b_rdy, b_busy, b_done, b_pass, b_fs;
  logic [1:0] b_vec, b_err;
  logic [7:0] b_cov;
  logic [2:0] b_ffa;
  logic [1:0] b_ffr;

  gate3_resp_checker #(.CNT_W(8)) dut8 (
    .CLK(CLK), .RST(RST), .start(start), .in_valid(in_valid), .in_abc(in_abc),
    .in_or(in_or), .in_nor(in_nor), .in_ready(a_rdy), .busy(a_busy), .done(a_done),
    .pass(a_pass), .vec_cnt(a_vec), .err_cnt(a_err), .cov(a_cov), .fail_seen(a_fs),
    .first_fail_abc(a_ffa), .first_fail_res(a_ffr));

  gate3_resp_checker #(.CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .start(start), .in_valid(in_valid), .in_abc(in_abc),
    .in_or(in_or), .in_nor(in_nor), .in_ready(b_rdy), .busy(b_busy), .done(b_done),
    .pass(b_pass), .vec_cnt(b_vec), .err_cnt(b_err), .cov(b_cov), .fail_seen(b_fs),
    .first_fail_abc(b_ffa), .first_fail_res(b_ffr));

  int checks = 0, errors = 0;

  // Reference model: plain counts and a set of seen vectors
  bit running = 0, finished = 0;
  int n_vec = 0, n_err = 0;
  bit seen [8];
  bit m_fs = 0;
  int m_ffa = 0, m_ffr = 0;
`ifdef GATE3_CHK_STOP_ON_ERR_EN
  bit stop_on_err = 1;
`else
  bit stop_on_err = 0;
`endif

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int seen_bits();
    int b = 0;
    for (int i = 0; i < 8; i++) if (seen[i]) b += (1 << i);
    return b;
  endfunction

  function automatic int n_seen();
    int c = 0;
    for (int i = 0; i < 8; i++) if (seen[i]) c++;
    return c;
  endfunction

  task automatic clear_model();
    n_vec = 0; n_err = 0; m_fs = 0; m_ffa = 0; m_ffr = 0;
    for (int i = 0; i < 8; i++) seen[i] = 0;
  endtask

  task automatic model_step(input bit r, input bit st, input bit v, input int abc,
                            input bit o, input bit n);
    bit wrong;
    if (r) begin
      clear_model(); running = 0; finished = 0;
    end else if (st) begin
      clear_model(); running = 1; finished = 0;
    end else if (running && v) begin
      n_vec++;
      seen[abc] = 1;
      wrong = (o != (abc != 0)) || (n != (abc == 0));
      if (wrong) begin
        n_err++;
        if (!m_fs) begin m_fs = 1; m_ffa = abc; m_ffr = o * 2 + n; end
      end
      if (n_seen() == 8 || (stop_on_err && wrong)) begin running = 0; finished = 1; end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rdy8", {31'd0, a_rdy}, running);
    chk("busy8", {31'd0, a_busy}, running);
    chk("done8", {31'd0, a_done}, finished);
    chk("pass8", {31'd0, a_pass}, finished && n_err == 0);
    chk("vec8", {24'd0, a_vec}, sat(n_vec, 255));
    chk("err8", {24'd0, a_err}, sat(n_err, 255));
    chk("cov8", {24'd0, a_cov}, seen_bits());
    chk("fs8", {31'd0, a_fs}, m_fs);
    chk("ffa8", {29'd0, a_ffa}, m_ffa);
    chk("ffr8", {30'd0, a_ffr}, m_ffr);
    chk("rdy2", {31'd0, b_rdy}, running);
    chk("done2", {31'd0, b_done}, finished);
    chk("pass2", {31'd0, b_pass}, finished && n_err == 0);
    chk("vec2", {30'd0, b_vec}, sat(n_vec, 3));
    chk("err2", {30'd0, b_err}, sat(n_err, 3));
    chk("cov2", {24'd0, b_cov}, seen_bits());
    chk("ffa2", {29'd0, b_ffa}, m_ffa);
    chk("ffr2", {30'd0, b_ffr}, m_ffr);
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge
  task automatic cyc(input bit r, input bit st, input bit v, input int abc,
                     input bit o, input bit n);
    RST = r; start = st; in_valid = v; in_abc = abc[2:0]; in_or = o; in_nor = n;
    model_step(r, st, v, abc, o, n);
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic beat(input int abc, input bit bad_or, input bit bad_nor);
    cyc(0, 0, 1, abc, (abc != 0) ^ bad_or, (abc == 0) ^ bad_nor);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic go();
    cyc(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    // reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 3, 1, 0);
    chk("reset_rdy", {31'd0, a_rdy}, 0);
    chk("reset_vec", {24'd0, a_vec}, 0);
    idle();

    // clean pass
    go();
    for (int i = 0; i < 8; i++) beat(i, 0, 0);
    chk("clean_done", {31'd0, a_done}, 1);
    chk("clean_pass", {31'd0, a_pass}, 1);
    chk("clean_vec", {24'd0, a_vec}, 8);
    chk("clean_cov", {24'd0, a_cov}, 8'hFF);
    idle();

    // single fault: nor=0 at 000
    go();
    beat(0, 0, 1);
`ifdef GATE3_CHK_STOP_ON_ERR_EN
    chk("fault_stop_done", {31'd0, a_done}, 1);
    chk("fault_stop_vec", {24'd0, a_vec}, 1);
`endif
    for (int i = 1; i < 8; i++) beat(i, 0, 0);
    chk("fault_err", {24'd0, a_err}, 1);
    chk("fault_ffa", {29'd0, a_ffa}, 0);
    chk("fault_ffr", {30'd0, a_ffr}, 0);
    chk("fault_pass", {31'd0, a_pass}, 0);

    // repeats and gaps
    go();
    for (int i = 0; i < 3; i++) beat(0, 0, 0);
    for (int i = 1; i < 8; i++) begin
      if (i % 2 == 1) idle();
      beat(i, 0, 0);
    end
    chk("rep_vec", {24'd0, a_vec}, 10);
    chk("rep_done", {31'd0, a_done}, 1);

    // restart with coincident beat
    go();
    for (int i = 0; i < 4; i++) beat(i, 0, 0);
    cyc(0, 1, 1, 5, 1, 0);
    chk("restart_vec", {24'd0, a_vec}, 0);
    chk("restart_cov", {24'd0, a_cov}, 0);
    for (int i = 0; i < 8; i++) beat(7 - i, 0, 0);
    chk("restart_full_vec", {24'd0, a_vec}, 8);

    // reset mid-run after a mismatch
    go();
    beat(0, 0, 0); beat(1, 1, 0); beat(2, 0, 0); beat(3, 0, 0); beat(4, 0, 0);
    cyc(1, 0, 1, 5, 1, 0);
    chk("rst_mid_rdy", {31'd0, a_rdy}, 0);
    chk("rst_mid_fs", {31'd0, a_fs}, 0);
    cyc(0, 0, 1, 6, 1, 0);

    // saturation: all-wrong beats
    go();
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, i, 1, 1);
`ifndef GATE3_CHK_STOP_ON_ERR_EN
    chk("sat_vec2", {30'd0, b_vec}, 3);
    chk("sat_err2", {30'd0, b_err}, 3);
    chk("sat_err8", {24'd0, a_err}, 8);
`endif
    chk("sat_pass2", {31'd0, b_pass}, 0);
    chk("sat_ffa2", {29'd0, b_ffa}, 0);

    // random traffic
    for (int run = 0; run < 8; run++) begin
      go();
      for (int k = 0; k < 80; k++) begin
        int  sel;
        int  abc;
        bit  v, bo, bn;
        sel = $urandom_range(0, 99);
        abc = $urandom_range(0, 7);
        v   = ($urandom_range(0, 3) != 0);
        bo  = ($urandom_range(0, 11) == 0);
        bn  = ($urandom_range(0, 11) == 0);
        if (sel == 0)      cyc(1, 0, v, abc, (abc != 0) ^ bo, (abc == 0) ^ bn);
        else if (sel == 1) cyc(0, 1, v, abc, (abc != 0) ^ bo, (abc == 0) ^ bn);
        else               cyc(0, 0, v, abc, (abc != 0) ^ bo, (abc == 0) ^ bn);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate3_resp_checker.md
# gate3_resp_checker

Self-checking response collector for the 3-input OR/NOR gate cells. It accepts sampled input vectors and the DUT's `or`/`nor` results over a valid/ready handshake and compares each against the expected logic function. It counts mismatches, records the first failure, and tracks coverage of all 8 input combinations. It sits at the receiving end of the 3-input stimulus sequence and turns a waveform-inspected gate test into a pass/fail verdict usable in simulation and on hardware.

## Interface
- `CNT_W`, default 8: width of the vector and error counters; both saturate at all-ones.

- `CLK` in 1: single clock; all state updates on its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that clears all results and begins a run.
- `in_valid` in 1: the sampled vector/result beat is valid.
- `in_abc` in 3: the sampled inputs, with `{a,b,c}` = bits `[2:0]`.
- `in_or` in 1: DUT OR3 output for `in_abc`.
- `in_nor` in 1: DUT NOR3 output for `in_abc`.
- `in_ready` out 1: the checker accepts a beat; high only in RUN.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `pass` out 1: high in DONE when `err_cnt` == 0.
- `vec_cnt` out CNT_W: number of beats accepted.
- `err_cnt` out CNT_W: number of mismatching beats.
- `cov` out 8: coverage bitmap; bit *n* is set once `in_abc` == *n* has been accepted.
- `fail_seen` out 1: at least one mismatch has occurred.
- `first_fail_abc` out 3: `in_abc` of the first mismatch.
- `first_fail_res` out 2: `{in_or,in_nor}` of the first mismatch.

## Operation
- **FSM states**
  - IDLE: the reset state. `in_ready`=0. `start` moves to RUN.
  - RUN: `in_ready`=1.
  - DONE: results held. `start` moves to RUN.
- **Accept:** a beat is accepted when `in_valid & in_ready`.
- **Expected values:** `exp_or` = |`in_abc`; `exp_nor` = ~|`in_abc`.
- **Mismatch:** `(in_or != exp_or) | (in_nor != exp_nor)`.
- **On each accept:**
  - `vec_cnt` += 1, saturating.
  - `cov[in_abc]` is set.
  - On a mismatch, `err_cnt` += 1 (saturating).
  - On a mismatch while `fail_seen`=0, `first_fail_*` is captured and `fail_seen` is set.
- **RUN→DONE:** taken on the accept after which `cov` == 8'hFF. Repeated vectors are legal; they count but do not change coverage.
- **`start` handling:**
  - `start` in any state clears `vec_cnt`, `err_cnt`, `cov`, `fail_seen` and `first_fail_*`, then enters RUN.
  - `start` has priority over a beat in the same cycle; that beat is not counted.
- **Reset values:** all outputs are 0 and the state is IDLE.
  - `RST` mid-run aborts the run with no result retained.
- **Counter saturation:** the counters hold at 2^CNT_W−1.
  - `pass` uses the saturated `err_cnt`, which is never 0 after a mismatch.

## Timing
- All outputs are registered. Effects of an accept in cycle *N* are visible in cycle *N+1*.
- `done`, `pass` and `busy`=0 assert in the cycle after the completing accept.
- `in_ready` drops in that same cycle.
- `in_ready` rises the cycle after `start`.
- Minimum run length: 8 accepts, i.e. `done` 9 cycles after `start` if `in_valid` is held high.
- Throughput: one beat per cycle in RUN; no bubbles.
- `start` and `RST` in the same cycle: `RST` wins.

## Configuration
- `GATE3_CHK_STOP_ON_ERR_EN`
  - **Defined:** the first mismatching accept also moves RUN→DONE in the following cycle, regardless of `cov`.
    - `pass`=0.
    - `cov` and `vec_cnt` reflect beats up to and including the failing one.
  - **Undefined:** the run always continues until full coverage and counts every error.

## Test plan
- **Clean pass:** `start`, then vectors 000..111 in stimulus order (c fastest) with correct `or`/`nor` → `done`=1 one cycle after the 8th accept; `pass`=1, `vec_cnt`=8, `err_cnt`=0, `cov`=8'hFF.
- **Single fault:** `nor` reported 0 for `abc`=000, others correct → `err_cnt`=1, `first_fail_abc`=3'b000, `first_fail_res`=2'b00, `pass`=0.
  - With the macro defined, `done` is high the cycle after beat 1 and `vec_cnt`=1.
- **Repeats and gaps:** vector 000 sent 3×, then 001..111 with `in_valid` gaps → `vec_cnt`=10, `cov`=8'hFF, `done` after the 10th accept; no beat is lost across the gaps.
- **Restart:** `start` asserted together with `in_valid` after 4 accepts → that beat is ignored; all results clear; a full 8-vector run then gives `vec_cnt`=8.
- **Reset:** `RST` after 5 accepts, including one mismatch → next cycle: IDLE, all outputs 0, `in_ready`=0.
- **Saturation:** `CNT_W`=2, 8 all-wrong beats (`or`=`nor`=1) → `vec_cnt`=3, `err_cnt`=3, `pass`=0, `first_fail_abc`=000.
